// File: rtl/idli_sqi_m.sv
// idli_sqi_m: quad-SPI instruction fetch, restarts a quad READ on redirect and streams nibbles to the decoder
module idli_sqi_m #(
  parameter logic [7:0] READ_CMD   = 8'h03,
  parameter logic [6:0] ADDR_UPPER = 7'h00
) (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst,
  input  logic [1:0]  i_sqi_ctr,
  input  logic        i_sqi_redirect,
  input  logic [15:0] i_sqi_addr,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_sck_en,
  output logic [3:0]  o_sqi_sio_out,
  output logic [3:0]  o_sqi_sio_oe,
  input  logic [3:0]  i_sqi_sio_in,
  output logic [3:0]  o_sqi_rd_data,
  output logic        o_sqi_rd_vld
);
  typedef enum logic [2:0] {IDLE, REDIRECT, CMD, ADDR, DUMMY, DATA} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q;
  logic [23:0] addr24;
  logic [4:0]  nib_idx;
  logic        active;
  assign addr24  = {ADDR_UPPER, addr_q, 1'b0};
  assign nib_idx = 5'd20 - {cnt_q[2:0], 2'b00};
  // A redirect wins everywhere except the slot-final cycle of REDIRECT, which launches the fetch
  always_comb begin
    state_d = state_q;
    if (i_sqi_redirect && !(state_q == REDIRECT && i_sqi_ctr == 2'd3))
      state_d = REDIRECT;
    else if (state_q == REDIRECT)
      state_d = i_sqi_redirect ? CMD : IDLE;
    else if (state_q == CMD && cnt_q == 4'd1)
      state_d = ADDR;
    else if (state_q == ADDR && cnt_q == 4'd5)
      state_d = DUMMY;
    else if (state_q == DUMMY && cnt_q == 4'd3)
      state_d = DATA;
  end
  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
      if (state_q == REDIRECT && state_d == CMD)
        addr_q <= i_sqi_addr;
    end
  end
  always_comb begin
    active        = state_q == CMD || state_q == ADDR || state_q == DUMMY || state_q == DATA;
    o_sqi_cs_n    = !active;
    o_sqi_sck_en  = active;
    o_sqi_sio_oe  = (state_q == CMD || state_q == ADDR) ? 4'hF : 4'h0;
    o_sqi_sio_out = (state_q == CMD)  ? (cnt_q[0] ? READ_CMD[3:0] : READ_CMD[7:4]) :
                    (state_q == ADDR) ? addr24[nib_idx +: 4] : 4'h0;
    o_sqi_rd_vld  = state_q == DATA;
    o_sqi_rd_data = o_sqi_rd_vld ? i_sqi_sio_in : 4'h0;
  end
endmodule

// File: tb/tb_idli_sqi_m.sv
// tb_idli_sqi_m: directed bench for idli_sqi_m with a fetch-sequence model and per-cycle comparison
module tb_idli_sqi_m;
  logic        clk = 1'b0, rst = 1'b1, redirect = 1'b0;
  logic [1:0]  ctr = 2'd0;
  logic [15:0] addr = 16'd0;
  logic [3:0]  sio_in = 4'd0;
  logic        cs_n0, sck0, rdv0, cs_n1, sck1, rdv1;
  logic [3:0]  sout0, oe0, rdd0, sout1, oe1, rdd1;
  int          checks = 0, errors = 0, ctr_v = 0;
  bit          chk_en = 1'b0;

  idli_sqi_m dut (
    .i_sqi_gck(clk), .i_sqi_rst(rst), .i_sqi_ctr(ctr), .i_sqi_redirect(redirect),
    .i_sqi_addr(addr), .o_sqi_cs_n(cs_n0), .o_sqi_sck_en(sck0), .o_sqi_sio_out(sout0),
    .o_sqi_sio_oe(oe0), .i_sqi_sio_in(sio_in), .o_sqi_rd_data(rdd0), .o_sqi_rd_vld(rdv0)
  );
  idli_sqi_m #(.ADDR_UPPER(7'h7F)) dut_hi (
    .i_sqi_gck(clk), .i_sqi_rst(rst), .i_sqi_ctr(ctr), .i_sqi_redirect(redirect),
    .i_sqi_addr(addr), .o_sqi_cs_n(cs_n1), .o_sqi_sck_en(sck1), .o_sqi_sio_out(sout1),
    .o_sqi_sio_oe(oe1), .i_sqi_sio_in(sio_in), .o_sqi_rd_data(rdd1), .o_sqi_rd_vld(rdv1)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", n, got, exp, $time);
    end
  endtask

  // Model: seq counts cycles since the fetch launched (-1 = no fetch); 0-7 command+address, 8-11 dummy, 12+ data
  int          seq = -1;
  bit          redir = 1'b0;
  logic [15:0] maddr = 16'd0;
  always @(posedge clk) begin
    if (rst) begin
      redir <= 1'b0;
      seq   <= -1;
    end else if (redirect && !(redir && ctr == 2'd3)) begin
      redir <= 1'b1;
      seq   <= -1;
    end else if (redir) begin
      redir <= 1'b0;
      seq   <= redirect ? 0 : -1;
      if (redirect) maddr <= addr;
    end else if (seq >= 0 && seq < 12) begin
      seq <= seq + 1;
    end
  end

  function automatic logic [3:0] exp_nib(logic [6:0] up, logic [15:0] a, int s);
    logic [31:0] w;
    w = {8'h03, up, a, 1'b0};
    if (s < 0 || s > 7) return 4'h0;
    return w[31-4*s -: 4];
  endfunction

  task automatic check_dut(string t, logic cs, logic sck, logic [3:0] so, logic [3:0] oe,
                           logic [3:0] rdd, logic rdv, logic [6:0] up);
    chk({t, "cs_n"}, {31'd0, cs}, {31'd0, seq < 0});
    chk({t, "sck_en"}, {31'd0, sck}, {31'd0, seq >= 0});
    chk({t, "sio_out"}, {28'd0, so}, {28'd0, exp_nib(up, maddr, seq)});
    chk({t, "sio_oe"}, {28'd0, oe}, (seq >= 0 && seq < 8) ? 32'hF : 32'h0);
    chk({t, "rd_vld"}, {31'd0, rdv}, {31'd0, seq >= 12});
    chk({t, "rd_data"}, {28'd0, rdd}, (seq >= 12) ? {28'd0, sio_in} : 32'h0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_dut("lo_", cs_n0, sck0, sout0, oe0, rdd0, rdv0, 7'h00);
      check_dut("hi_", cs_n1, sck1, sout1, oe1, rdd1, rdv1, 7'h7F);
    end
  end

  task automatic drive(bit r_st, bit r, logic [15:0] a, logic [3:0] s);
    #1;
    rst = r_st; redirect = r; addr = a; sio_in = s;
    ctr = 2'(ctr_v);
    ctr_v++;
    @(negedge clk);
  endtask

  logic [3:0] e1 [8] = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h2, 4'h4, 4'h6, 4'h8};
  logic [3:0] e2 [8] = '{4'h0, 4'h3, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hE};
  logic [3:0] e0 [8] = '{4'h0, 4'h3, 4'h0, 4'h1, 4'hF, 4'hF, 4'hF, 4'hE};
  logic [3:0] e3 [8] = '{4'h0, 4'h3, 4'h0, 4'h1, 4'h5, 4'h7, 4'h9, 4'hA};
  logic [3:0] dv [4] = '{4'h5, 4'hA, 4'hF, 4'h0};

  initial begin
    for (int i = 0; i < 4; i++) drive(1, 0, 16'h0, 4'h0);
    chk_en = 1'b1;
    chk("rst_cs_n", {31'd0, cs_n0}, 1);
    chk("rst_sck_en", {31'd0, sck0}, 0);
    chk("rst_oe", {28'd0, oe0}, 0);
    chk("rst_rd_vld", {31'd0, rdv0}, 0);
    // fetch from 16'h1234
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 16'h1234, 4'h0);
      if (i < 3) chk("redir_cs_n", {31'd0, cs_n0}, 1);
    end
    for (int i = 0; i < 8; i++) begin
      chk("f1_sio", {28'd0, sout0}, {28'd0, e1[i]});
      chk("f1_oe", {28'd0, oe0}, 32'hF);
      drive(0, 0, 16'h0, 4'h0);
    end
    for (int i = 0; i < 4; i++) begin
      chk("f1_dummy_oe", {28'd0, oe0}, 0);
      chk("f1_dummy_vld", {31'd0, rdv0}, 0);
      drive(0, 0, 16'h0, 4'h0);
    end
    chk("f1_first_vld", {31'd0, rdv0}, 1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 16'h0, dv[i]);
      chk("f1_rd_data", {28'd0, rdd0}, {28'd0, dv[i]});
      chk("f1_rd_vld", {31'd0, rdv0}, 1);
    end
    // fetch from 16'hFFFF, both address-upper settings
    for (int i = 0; i < 4; i++) drive(0, 1, 16'hFFFF, 4'h0);
    for (int i = 0; i < 8; i++) begin
      chk("f2_hi_sio", {28'd0, sout1}, {28'd0, e2[i]});
      chk("f2_lo_sio", {28'd0, sout0}, {28'd0, e0[i]});
      drive(0, 0, 16'h0, 4'h0);
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 16'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 16'h0, 4'(i * 3 + 1));
      chk("f2_hi_rd_data", {28'd0, rdd1}, 32'(i * 3 + 1));
    end
    // abort during the third address nibble, relaunch at 16'hABCD
    for (int i = 0; i < 4; i++) drive(0, 1, 16'h1234, 4'h0);
    for (int i = 0; i < 4; i++) drive(0, 0, 16'h0, 4'h0);
    chk("ab_third_nib", {28'd0, sout0}, 32'h2);
    drive(0, 1, 16'hABCD, 4'h0);
    chk("ab_cs_n", {31'd0, cs_n0}, 1);
    chk("ab_oe", {28'd0, oe0}, 0);
    chk("ab_sck_en", {31'd0, sck0}, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 16'hABCD, 4'h0);
    for (int i = 0; i < 8; i++) begin
      chk("ab_resq_sio", {28'd0, sout0}, {28'd0, e3[i]});
      drive(0, 0, 16'h0, 4'h0);
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 16'h0, 4'h0);
    chk("ab_data_vld", {31'd0, rdv0}, 1);
    // malformed half-slot redirect
    drive(0, 1, 16'h5555, 4'h0);
    drive(0, 1, 16'h5555, 4'h0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 16'h5555, 4'h0);
      chk("mal_cs_n", {31'd0, cs_n0}, 1);
      chk("mal_oe", {28'd0, oe0}, 0);
    end
    // reset during DATA
    for (int i = 0; i < 4; i++) drive(0, 1, 16'h0100, 4'h0);
    for (int i = 0; i < 14; i++) drive(0, 0, 16'h0, 4'h7);
    chk("pre_rst_vld", {31'd0, rdv0}, 1);
    drive(1, 0, 16'h0, 4'h9);
    chk("mrst_cs_n", {31'd0, cs_n0}, 1);
    chk("mrst_sck_en", {31'd0, sck0}, 0);
    chk("mrst_sio", {28'd0, sout0}, 0);
    chk("mrst_oe", {28'd0, oe0}, 0);
    chk("mrst_vld", {31'd0, rdv0}, 0);
    chk("mrst_rd_data", {28'd0, rdd0}, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 16'h0, 4'h9);
      chk("post_rst_cs_n", {31'd0, cs_n0}, 1);
      chk("post_rst_rd_data", {28'd0, rdd0}, 0);
    end
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
